// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store sequencer. It accepts one access from execute, runs a
// single req/ack transaction on the data-memory bus, and returns the
// extended load data. Misaligned, illegal or timed-out accesses raise a fault pulse.
module lsu_ctrl #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_MemRead,
    input  logic        i_MemWrite,
    input  logic [2:0]  i_Funct3,
    input  logic [31:0] i_Addr,
    input  logic [31:0] i_WData,
    output logic [31:0] o_RData,
    output logic        o_Stall,
    output logic        o_Done,
    output logic        o_Fault,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [3:0]  o_bus_be,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_ack,
    input  logic [31:0] i_bus_rdata
);
    // Counter only needs to reach TIMEOUT_CYC-1: the last waiting cycle is
    // detected by compare, not by overflow.
    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [2:0]  funct3;
        logic [1:0]  off;
    } acc_t;

    state_t        state, state_nxt;
    acc_t          acc_q, acc_nxt;
    logic [CW-1:0] wait_cnt;
    logic          fault_q;
    logic          req_any, bad_f3, misaligned, legal;
    logic          accept, timeout;
    logic [7:0]    byte_w;
    logic [15:0]   half_w;
    logic [31:0]   ext;

    // Decode the presented access: legality plus bus image to latch on accept
    always_comb begin
        req_any    = i_MemRead | i_MemWrite;
        // Stores win when both strobes are high, so legality follows MemWrite
        if (i_MemWrite)
            bad_f3 = i_Funct3[2] | (i_Funct3[1:0] == 2'b11);
        else
            bad_f3 = (i_Funct3 == 3'b011) | (i_Funct3[2:1] == 2'b11);
        misaligned = ((i_Funct3[1:0] == 2'b01) & i_Addr[0]) |
                     ((i_Funct3[1:0] == 2'b10) & (i_Addr[1:0] != 2'b00));
        legal      = ~bad_f3 & ~misaligned;

        acc_nxt.we     = i_MemWrite;
        acc_nxt.addr   = {i_Addr[31:2], 2'b00};
        acc_nxt.funct3 = i_Funct3;
        acc_nxt.off    = i_Addr[1:0];
        acc_nxt.be     = 4'b1111;
        acc_nxt.wdata  = i_WData;
        case (i_Funct3[1:0])
            2'b00: begin
                acc_nxt.be    = 4'b0001 << i_Addr[1:0];
                acc_nxt.wdata = {4{i_WData[7:0]}};
            end
            2'b01: begin
                acc_nxt.be    = i_Addr[1] ? 4'b1100 : 4'b0011;
                acc_nxt.wdata = {2{i_WData[15:0]}};
            end
            default: begin
                acc_nxt.be    = 4'b1111;
                acc_nxt.wdata = i_WData;
            end
        endcase
        // Loads always fetch the whole word; lane selection happens on return
        if (!i_MemWrite)
            acc_nxt.be = 4'b1111;
    end

    // Pick the addressed lane out of the returned word and extend it
    always_comb begin
        byte_w = i_bus_rdata[{acc_q.off, 3'b000} +: 8];
        half_w = acc_q.off[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];
        case (acc_q.funct3)
            3'b000:  ext = {{24{byte_w[7]}}, byte_w};
            3'b001:  ext = {{16{half_w[15]}}, half_w};
            3'b100:  ext = {24'd0, byte_w};
            3'b101:  ext = {16'd0, half_w};
            default: ext = i_bus_rdata;
        endcase
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next state and handshake outputs; DONE ignores the still-presented access
    always_comb begin
        state_nxt = state;
        o_Stall   = 1'b0;
        o_bus_req = 1'b0;
        o_Done    = 1'b0;
        accept    = 1'b0;
        timeout   = 1'b0;
        case (state)
            IDLE: begin
                if (req_any && legal) begin
                    accept    = 1'b1;
                    o_Stall   = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                o_bus_req = 1'b1;
                o_Stall   = 1'b1;
                // A late ack still beats the timeout on the same cycle
                if (i_bus_ack) begin
                    state_nxt = DONE;
                end else if (wait_cnt == CW'(TIMEOUT_CYC - 1)) begin
                    timeout   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            DONE: begin
                o_Done    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (i_rst)
            o_Stall = 1'b0;
    end

    // Latched access, wait counter, load result and fault pulse
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc_q    <= '0;
            wait_cnt <= '0;
            fault_q  <= 1'b0;
            o_RData  <= '0;
        end else begin
            fault_q <= ((state == IDLE) && req_any && !legal) || timeout;
            if (accept) begin
                acc_q    <= acc_nxt;
                wait_cnt <= '0;
            end else if ((state == REQ) && !i_bus_ack && !timeout) begin
                wait_cnt <= wait_cnt + CW'(1);
            end
            if ((state == REQ) && i_bus_ack && !acc_q.we)
                o_RData <= ext;
        end
    end

    assign o_Fault     = fault_q;
    assign o_bus_we    = acc_q.we;
    assign o_bus_addr  = acc_q.addr;
    assign o_bus_be    = acc_q.be;
    assign o_bus_wdata = acc_q.wdata;
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed + randomized accesses; expected outcomes are queued
// at issue time and checked by an independent monitor.
module tb_lsu_ctrl;
    localparam int TO = 16;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_MemRead = 1'b0, i_MemWrite = 1'b0;
    logic [2:0]  i_Funct3 = '0;
    logic [31:0] i_Addr = '0, i_WData = '0;
    logic [31:0] o_RData;
    logic        o_Stall, o_Done, o_Fault;
    logic        o_bus_req, o_bus_we;
    logic [31:0] o_bus_addr, o_bus_wdata;
    logic [3:0]  o_bus_be;
    logic        i_bus_ack = 1'b0;
    logic [31:0] i_bus_rdata = '0;

    always #5 i_clk = ~i_clk;

    lsu_ctrl #(.TIMEOUT_CYC(TO)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_MemRead(i_MemRead), .i_MemWrite(i_MemWrite), .i_Funct3(i_Funct3),
        .i_Addr(i_Addr), .i_WData(i_WData),
        .o_RData(o_RData), .o_Stall(o_Stall), .o_Done(o_Done), .o_Fault(o_Fault),
        .o_bus_req(o_bus_req), .o_bus_we(o_bus_we), .o_bus_addr(o_bus_addr),
        .o_bus_be(o_bus_be), .o_bus_wdata(o_bus_wdata),
        .i_bus_ack(i_bus_ack), .i_bus_rdata(i_bus_rdata)
    );

    typedef enum logic [1:0] {K_DONE, K_FAULT, K_ABORT} kind_e;
    typedef struct {
        kind_e       kind;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    exp_t        exp_q[$];
    int          n_pass = 0, n_total = 0;
    logic [31:0] last_rd = '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, want, $time);
    endtask

    // ---------------- reference model ----------------
    function automatic int m_size(input logic [2:0] f3);
        return 1 << (f3 % 4);
    endfunction

    function automatic bit m_legal(input bit wr, input logic [2:0] f3, input logic [31:0] a);
        if (wr) begin
            if (f3 > 2) return 1'b0;
        end else if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) begin
            return 1'b0;
        end
        return (a % m_size(f3)) == 0;
    endfunction

    function automatic logic [3:0] m_be(input bit wr, input logic [2:0] f3, input logic [31:0] a);
        if (!wr) return 4'hF;
        case (m_size(f3))
            1:       return 4'(1 << (a % 4));
            2:       return 4'(3 << (a % 4));
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
        case (m_size(f3))
            1:       return (wd & 32'hFF) * 32'h0101_0101;
            2:       return (wd & 32'hFFFF) * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v;
        v = rd >> (8 * (a % 4));
        if (m_size(f3) == 1) begin
            v = v & 32'hFF;
            if (f3 == 3'd0 && v >= 128) v = v - 256;
        end else if (m_size(f3) == 2) begin
            v = v & 32'hFFFF;
            if (f3 == 3'd1 && v >= 32768) v = v - 65536;
        end
        return v;
    endfunction

    // ---------------- monitor ----------------
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge i_clk);
            if (!i_rst) begin
                if (o_bus_req) begin
                    check("bus_expected", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        check("bus_we", o_bus_we, exp_q[0].we);
                        check("bus_addr", o_bus_addr, exp_q[0].addr);
                        check("bus_be", o_bus_be, exp_q[0].be);
                        if (exp_q[0].we) check("bus_wdata", o_bus_wdata, exp_q[0].wdata);
                    end
                end
                if (o_Done || o_Fault) begin
                    check("result_expected", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("done_flag", o_Done, e.kind == K_DONE);
                        check("fault_flag", o_Fault, e.kind == K_FAULT);
                        if (o_Done) check("rdata", o_RData, e.rdata);
                    end
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic drive_req(input bit rd, input bit wr, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd);
        i_MemRead = rd; i_MemWrite = wr; i_Funct3 = f3; i_Addr = a; i_WData = wd;
    endtask

    task automatic drop_req();
        i_MemRead = 1'b0; i_MemWrite = 1'b0;
        i_Funct3 = 3'($urandom); i_Addr = $urandom; i_WData = $urandom;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge i_clk); #1;
            drop_req();
            i_bus_ack = 1'($urandom_range(0, 1));
            i_bus_rdata = $urandom;
            @(negedge i_clk);
            check("idle_noreq", o_bus_req, 0);
        end
    endtask

    // waits < 0: never acknowledge (timeout expected)
    task automatic do_access(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, input int waits, input logic [31:0] rdat);
        exp_t e;
        bit   legal, acked;
        int   stalls, reqs;
        legal   = m_legal(wr, f3, a);
        e.kind  = (!legal || waits < 0) ? K_FAULT : K_DONE;
        e.we    = wr;
        e.addr  = a & 32'hFFFF_FFFC;
        e.be    = m_be(wr, f3, a);
        e.wdata = m_wdata(f3, wd);
        e.rdata = wr ? last_rd : m_load(f3, a, rdat);
        if (e.kind == K_DONE) last_rd = e.rdata;
        exp_q.push_back(e);

        @(posedge i_clk); #1;
        drive_req(rd, wr, f3, a, wd);
        i_bus_ack = 1'b0;
        @(negedge i_clk);
        check("stall_c0", o_Stall, legal);
        if (!legal) begin
            check("illegal_noreq", o_bus_req, 0);
            @(posedge i_clk); #1;
            drop_req();
            @(negedge i_clk);
            check("illegal_fault", o_Fault, 1);
            check("illegal_noreq2", o_bus_req, 0);
            return;
        end

        stalls = 1; reqs = 0; acked = 1'b0;
        while (!acked && reqs < TO + 4) begin
            @(posedge i_clk); #1;
            if (waits < 0 && reqs == TO) drop_req();
            i_bus_ack   = (waits >= 0 && reqs == waits);
            i_bus_rdata = i_bus_ack ? rdat : $urandom;
            @(negedge i_clk);
            if (!o_bus_req) break;
            reqs++;
            if (o_Stall) stalls++;
            acked = i_bus_ack;
        end

        if (waits < 0) begin
            check("timeout_req_cycles", reqs, TO);
            check("timeout_fault", o_Fault, 1);
            check("timeout_nostall", o_Stall, 0);
            @(posedge i_clk); #1;
            drop_req();
            return;
        end

        check("acked", acked, 1);
        check("req_cycles", reqs, waits + 1);
        check("stall_cycles", stalls, waits + 2);
        // DONE cycle: the same instruction is still presented
        @(posedge i_clk); #1;
        i_bus_ack = 1'b0; i_bus_rdata = $urandom;
        @(negedge i_clk);
        check("done_pulse", o_Done, 1);
        check("done_nostall", o_Stall, 0);
        check("done_noreq", o_bus_req, 0);
        @(posedge i_clk); #1;
        drop_req();
        @(negedge i_clk);
        check("no_reissue", o_bus_req, 0);
        check("done_one_cycle", o_Done, 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_req"}, o_bus_req, 0);
        check({tag, "_we"}, o_bus_we, 0);
        check({tag, "_addr"}, o_bus_addr, 0);
        check({tag, "_be"}, o_bus_be, 0);
        check({tag, "_wdata"}, o_bus_wdata, 0);
        check({tag, "_rdata"}, o_RData, 0);
        check({tag, "_done"}, o_Done, 0);
        check({tag, "_fault"}, o_Fault, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        logic [2:0] legal_ld [5];
        exp_t       e;
        int         r, waits, off, sz;
        bit         rd, wr;
        logic [2:0] f3;
        legal_ld = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

        // Reset with an access presented: no stall, reset values
        repeat (2) @(posedge i_clk);
        #1 drive_req(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
        @(negedge i_clk);
        check("rst_stall", o_Stall, 0);
        check_reset_vals("rst");
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        drop_req();

        // Directed cases
        do_access(1, 0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF);
        do_access(1, 0, 3'b000, 32'h103, 32'h0, 2, 32'h80FF0000);
        do_access(1, 0, 3'b100, 32'h103, 32'h0, 2, 32'h80FF0000);
        do_access(0, 1, 3'b001, 32'h202, 32'h0000ABCD, 0, $urandom);
        do_access(1, 0, 3'b010, 32'h101, 32'h0, 0, $urandom);
        do_access(1, 0, 3'b011, 32'h100, 32'h0, 0, $urandom);
        do_access(1, 0, 3'b010, 32'h104, 32'h0, -1, $urandom);
        do_access(1, 0, 3'b010, 32'h108, 32'h0, TO - 1, 32'h12345678);
        do_access(1, 1, 3'b000, 32'h011, 32'h0000005A, 1, $urandom);
        do_access(1, 0, 3'b101, 32'h00E, 32'h0, 1, 32'h8001_7FFF);
        idle(3);

        // Reset during the third REQ cycle
        e.kind = K_ABORT; e.we = 1'b0; e.addr = 32'h300; e.be = 4'hF;
        e.wdata = '0; e.rdata = '0;
        exp_q.push_back(e);
        @(posedge i_clk); #1;
        drive_req(1'b1, 1'b0, 3'b010, 32'h300, 32'h0);
        i_bus_ack = 1'b0;
        @(negedge i_clk);
        check("abort_stall_c0", o_Stall, 1);
        repeat (2) begin
            @(posedge i_clk); #1;
            @(negedge i_clk);
            check("abort_req", o_bus_req, 1);
        end
        @(posedge i_clk); #1;
        i_rst = 1'b1;
        @(negedge i_clk);
        check("abort_rst_stall", o_Stall, 0);
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        drop_req();
        @(negedge i_clk);
        check_reset_vals("abort");
        check("abort_pending", 32'(exp_q.size()), 1);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        last_rd = '0;
        do_access(1, 0, 3'b010, 32'h400, 32'h0, 0, 32'hCAFEF00D);

        // Randomized traffic
        for (int t = 0; t < 150; t++) begin
            r  = $urandom_range(0, 9);
            rd = (r < 5) || (r == 9);
            wr = (r >= 5);
            if (wr) f3 = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) : 3'($urandom);
            else    f3 = ($urandom_range(0, 9) < 8) ? legal_ld[$urandom_range(0, 4)] : 3'($urandom);
            sz  = m_size(f3);
            off = $urandom_range(0, 3);
            if ($urandom_range(0, 9) < 8) off = off - (off % sz);
            waits = ($urandom_range(0, 19) == 0) ? TO - 1 : $urandom_range(0, 3);
            do_access(rd, wr, f3, ($urandom & 32'hFFFF_FFFC) | 32'(off), $urandom, waits, $urandom);
            idle($urandom_range(0, 2));
        end

        idle(2);
        check("sb_drained", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store sequencer between the execute stage and the data-memory bus. It consumes the MemRead/MemWrite strobes produced by main control plus funct3, ALU address and rs2 data. It then runs a single req/ack bus transaction with byte enables, stalling the pipeline until completion. It returns the sign- or zero-extended load result, and flags misaligned, unsupported or timed-out accesses.

## Interface
- TIMEOUT_CYC, 16: max cycles in REQ without ack before abort (≥1)
- i_clk  in  1  clock, all state on rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_MemRead  in  1  load request from main control
- i_MemWrite  in  1  store request from main control
- i_Funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (stores: 000/001/010 only)
- i_Addr  in  32  byte address (ALU result)
- i_WData  in  32  store data (rs2)
- o_RData  out  32  extended load data, valid when o_Done=1 for a load
- o_Stall  out  1  hold pipeline
- o_Done  out  1  one-cycle completion pulse
- o_Fault  out  1  one-cycle pulse: misaligned, illegal funct3, or timeout
- o_bus_req  out  1  bus request, held until ack
- o_bus_we  out  1  1 = write
- o_bus_addr  out  32  word address, i_Addr with [1:0]=00
- o_bus_be  out  4  byte enables
- o_bus_wdata  out  32  lane-replicated store data
- i_bus_ack  in  1  transaction complete (sampled only while o_bus_req=1)
- i_bus_rdata  in  32  read word, valid with ack

## Operation
- States: IDLE, REQ, DONE.
- Request = i_MemRead | i_MemWrite. Both high: treated as store (MemWrite priority).
- IDLE, request, legal and aligned: latch we/addr/be/wdata/funct3/byte offset, go REQ. o_Stall=1 combinationally this cycle.
- IDLE, request, illegal: o_Fault=1 next cycle, stay IDLE, no bus activity, o_Stall=0.
  - Illegal funct3 for load: 011, 110, 111. For store: anything other than 000/001/010.
  - Misaligned: H/HU with addr[0]=1, or W with addr[1:0]≠00.
- REQ: o_bus_req=1, o_Stall=1, bus outputs stable.
  - On ack: capture extended rdata into o_RData (loads only; stores leave o_RData unchanged), go DONE.
  - Else increment wait counter. At TIMEOUT_CYC cycles without ack: drop req, o_Fault=1 next cycle, go IDLE, no o_Done.
- DONE: o_Done=1, o_Stall=0, o_bus_req=0. Always return to IDLE. Never re-issues, even though the same instruction is still presented.
- Byte enables:
  - B: be = 1<<addr[1:0], wdata = {4{byte}}.
  - H: be = addr[1] ? 1100 : 0011, wdata = {2{half}}.
  - W: be = 1111.
- Load extract: byte lane addr[1:0] / half lane addr[1]. B/H sign-extend from bit 7/15; BU/HU zero-extend.
- Loads drive be=1111 on the bus; extraction is internal.

## Timing
- Reset values: state IDLE, o_bus_req 0, o_bus_we 0, o_bus_addr 0, o_bus_be 0, o_bus_wdata 0, o_RData 0, o_Done 0, o_Fault 0, wait counter 0. o_Stall=0 while i_rst=1.
- Zero-wait access: request at cycle 0 (stall), req+ack at cycle 1 (stall), DONE at cycle 2 (no stall, o_Done, o_RData valid). Total 2 stall cycles; each bus wait state adds 1.
- o_bus_req falls the cycle after ack.
- Ack while o_bus_req=0 is ignored.
- Reset mid-REQ: req low the following cycle; no o_Done, no o_Fault.
- Timeout: req high exactly TIMEOUT_CYC cycles, fault pulse on the next cycle.
- An ack on the same cycle the counter reaches TIMEOUT_CYC wins: the access completes normally.

## Test plan
- LW addr 0x100, ack on first REQ cycle, rdata 0xDEADBEEF -> stall cycles 0–1, cycle 2 o_Done=1, o_RData=0xDEADBEEF, bus_addr 0x100, be 1111.
- LB addr 0x103, rdata 0x80FF0000, 2 wait states -> o_RData=0xFFFFFF80 at cycle 4. LBU on the same access -> 0x00000080.
- SH addr 0x202, wdata 0x0000ABCD -> bus_we=1, bus_addr 0x200, be 1100, bus_wdata 0xABCDABCD, o_RData unchanged.
- LW addr 0x101 or funct3=011 -> no req, o_Stall=0, o_Fault pulse next cycle.
- LW with ack never asserted, TIMEOUT_CYC=16 -> req high 16 cycles, then o_Fault=1 for one cycle, IDLE, stall released.
- i_rst asserted during the 3rd REQ cycle -> next cycle req=0, all outputs at reset values. A fresh LW after reset completes normally.
